// File: rtl/color_tracker_pkg.sv
// Shared constants, state encoding and RGB565 field positions for the colour
// centroid tracker and its serial dividers.
package color_tracker_pkg;

  // Default frame geometry and the detection threshold
  localparam int IMG_W_DEF      = 320;
  localparam int IMG_H_DEF      = 240;
  localparam int MIN_PIXELS_DEF = 64;

  // Datapath widths: column, row, coordinate sums and match count
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int SUM_W = 25;
  localparam int CNT_W = 17;

  // RGB565 field positions
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  // Result FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Inclusive window test; an inverted window (lo > hi) never matches
  function automatic logic inWindow(input logic [5:0] v,
                                    input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/color_centroid_tracker_serial_divider.sv
// Restoring serial divider: 25-bit dividend by 17-bit divisor, one quotient
// bit per cycle, MSB first. o_done pulses for one cycle when the quotient is
// ready and the quotient then holds until the next start.
module serial_divider
  import color_tracker_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [SUM_W-1:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  output logic [SUM_W-1:0] o_quotient,
  output logic             o_done
);

  logic [CNT_W-1:0] r_rem;
  logic [SUM_W-1:0] r_quo;
  logic [CNT_W-1:0] r_div;
  logic [4:0]       r_iter;
  logic             r_active;
  logic             r_done;

  logic [CNT_W:0]   w_trial;
  logic             w_fits;
  logic [CNT_W-1:0] w_diff;

  // Shift the next dividend bit into the partial remainder and try a subtract;
  // when it fits the difference is below the divisor, so 17 bits are enough
  always_comb begin
    w_trial = {r_rem, r_quo[SUM_W-1]};
    w_fits  = (w_trial >= {1'b0, r_div});
    w_diff  = w_trial[CNT_W-1:0] - r_div;
  end

  // Load operands on start, then retire one quotient bit per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_iter   <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo    <= i_dividend;
        r_rem    <= '0;
        r_div    <= i_divisor;
        r_iter   <= 5'(SUM_W);
        r_active <= 1'b1;
      end else if (r_active) begin
        r_rem  <= w_fits ? w_diff : w_trial[CNT_W-1:0];
        r_quo  <= {r_quo[SUM_W-2:0], w_fits};
        r_iter <= r_iter - 5'd1;
        if (r_iter == 5'd1) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;

endmodule

// File: rtl/color_centroid_tracker.sv
// Per-frame colour centroid: counts RGB565 pixels inside a colour window,
// sums their coordinates and divides at frame end to give (cx, cy).
module color_centroid_tracker
  import color_tracker_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             frame_active,
  input  logic             pix_valid,
  input  logic [15:0]      pix_data,
  input  logic [4:0]       r_min,
  input  logic [4:0]       r_max,
  input  logic [5:0]       g_min,
  input  logic [5:0]       g_max,
  input  logic [4:0]       b_min,
  input  logic [4:0]       b_max,
  output logic [X_W-1:0]   cx,
  output logic [Y_W-1:0]   cy,
  output logic [CNT_W-1:0] match_count,
  output logic             target_found,
  output logic             result_valid,
  output logic             busy
);

  logic             r_faDly;
  logic [4:0]       r_rMinSh, r_rMaxSh, r_bMinSh, r_bMaxSh;
  logic [5:0]       r_gMinSh, r_gMaxSh;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_s1Match;
  logic [X_W-1:0]   r_s1X;
  logic [Y_W-1:0]   r_s1Y;
  logic [SUM_W-1:0] r_sumX, r_sumY;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cntSnap;
  logic [1:0]       r_endPipe;
  state_t           r_state, w_nextState;

  logic             w_rise, w_fall, w_pixIn, w_match, w_snap, w_startDiv;
  logic [4:0]       w_rLo, w_rHi, w_bLo, w_bHi;
  logic [5:0]       w_gLo, w_gHi;
  logic [X_W-1:0]   w_xCur, w_cxSat;
  logic [Y_W-1:0]   w_yCur, w_cySat;
  logic [SUM_W-1:0] w_quoX, w_quoY;
  logic             w_doneX, w_doneY;

  // On the frame-start cycle the shadows are not loaded yet, so a pixel
  // arriving together with the rising edge uses the live thresholds and
  // starts from coordinate (0,0)
  always_comb begin
    w_rise  = frame_active & ~r_faDly;
    w_fall  = ~frame_active & r_faDly;
    w_pixIn = pix_valid & frame_active;
    w_rLo   = w_rise ? r_min : r_rMinSh;
    w_rHi   = w_rise ? r_max : r_rMaxSh;
    w_gLo   = w_rise ? g_min : r_gMinSh;
    w_gHi   = w_rise ? g_max : r_gMaxSh;
    w_bLo   = w_rise ? b_min : r_bMinSh;
    w_bHi   = w_rise ? b_max : r_bMaxSh;
    w_xCur  = w_rise ? '0 : r_x;
    w_yCur  = w_rise ? '0 : r_y;
    w_match = inWindow({1'b0, pix_data[R_HI:R_LO]}, {1'b0, w_rLo}, {1'b0, w_rHi})
            & inWindow(pix_data[G_HI:G_LO], w_gLo, w_gHi)
            & inWindow({1'b0, pix_data[B_HI:B_LO]}, {1'b0, w_bLo}, {1'b0, w_bHi});
    w_snap  = r_endPipe[1];
  end

  // frame_active history for edge detection and the two-cycle drain delay
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_faDly   <= 1'b0;
      r_endPipe <= '0;
    end else begin
      r_faDly   <= frame_active;
      r_endPipe <= {r_endPipe[0], w_fall};
    end
  end

  // Freeze the colour window at frame start so mid-frame edits wait a frame
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_rMinSh <= '0; r_rMaxSh <= '0;
      r_gMinSh <= '0; r_gMaxSh <= '0;
      r_bMinSh <= '0; r_bMaxSh <= '0;
    end else if (w_rise) begin
      r_rMinSh <= r_min; r_rMaxSh <= r_max;
      r_gMinSh <= g_min; r_gMaxSh <= g_max;
      r_bMinSh <= b_min; r_bMaxSh <= b_max;
    end
  end

  // Raster position: x wraps at line end, y sticks on the last row
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pixIn) begin
      if (w_xCur == X_W'(IMG_W - 1)) begin
        r_x <= '0;
        r_y <= (w_yCur == Y_W'(IMG_H - 1)) ? w_yCur : w_yCur + Y_W'(1);
      end else begin
        r_x <= w_xCur + X_W'(1);
        r_y <= w_yCur;
      end
    end else if (w_rise) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // Stage 1: register the match decision with the pixel's coordinates
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_s1Match <= 1'b0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
    end else begin
      r_s1Match <= w_pixIn & w_match;
      r_s1X     <= w_xCur;
      r_s1Y     <= w_yCur;
    end
  end

  // Stage 2: accumulate matching coordinates; frame start discards stale data
  always_ff @(posedge dclk) begin
    if (rst || w_rise) begin
      r_sumX <= '0;
      r_sumY <= '0;
      r_cnt  <= '0;
    end else if (r_s1Match) begin
      r_sumX <= r_sumX + SUM_W'(r_s1X);
      r_sumY <= r_sumY + SUM_W'(r_s1Y);
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // The dividers capture the live sums on start, which acts as the snapshot
  serial_divider u_divX (
    .i_clk      (dclk),
    .i_rst      (rst),
    .i_start    (w_startDiv),
    .i_dividend (r_sumX),
    .i_divisor  (r_cnt),
    .o_quotient (w_quoX),
    .o_done     (w_doneX)
  );

  serial_divider u_divY (
    .i_clk      (dclk),
    .i_rst      (rst),
    .i_start    (w_startDiv),
    .i_dividend (r_sumY),
    .i_divisor  (r_cnt),
    .o_quotient (w_quoY),
    .o_done     (w_doneY)
  );

  // Result FSM state register and count snapshot; a frame end that lands
  // while a division is running is ignored
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cntSnap <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_snap) begin
        r_cntSnap <= r_cnt;
      end
    end
  end

  // Next state: an empty frame skips the divide and reports zero
  always_comb begin
    w_nextState = r_state;
    w_startDiv  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_snap) begin
          if (r_cnt != '0) begin
            w_startDiv  = 1'b1;
            w_nextState = DIVIDE;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      DIVIDE: begin
        if (w_doneX && w_doneY) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A mean coordinate can never exceed the image, but clamp rather than
  // silently drop high quotient bits
  always_comb begin
    w_cxSat = (|w_quoX[SUM_W-1:X_W]) ? X_W'(IMG_W - 1) : w_quoX[X_W-1:0];
    w_cySat = (|w_quoY[SUM_W-1:Y_W]) ? Y_W'(IMG_H - 1) : w_quoY[Y_W-1:0];
  end

  // Publish the result when leaving DONE; outputs hold until the next one
  always_ff @(posedge dclk) begin
    if (rst) begin
      cx           <= '0;
      cy           <= '0;
      match_count  <= '0;
      target_found <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (r_state == DONE) begin
        cx           <= (r_cntSnap == '0) ? '0 : w_cxSat;
        cy           <= (r_cntSnap == '0) ? '0 : w_cySat;
        match_count  <= r_cntSnap;
        target_found <= (r_cntSnap >= CNT_W'(MIN_PIXELS));
        result_valid <= 1'b1;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Scoreboard bench for color_centroid_tracker: each frame pushes its
// hand-computed result; a monitor pops and compares on every result_valid.
module tb_color_centroid_tracker;

  logic        dclk = 1'b0;
  logic        rst;
  logic        frame_active;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [16:0] match_count;
  logic        target_found;
  logic        result_valid;
  logic        busy;

  typedef struct {
    string name;
    int    cx;
    int    cy;
    int    cnt;
    int    tf;
    bit    skip;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   errors    = 0;
  int   checks    = 0;
  int   cycle     = 0;
  int   fallCycle = 0;
  int   lat;

  color_centroid_tracker dut (
    .dclk         (dclk),
    .rst          (rst),
    .frame_active (frame_active),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .r_min        (r_min),
    .r_max        (r_max),
    .g_min        (g_min),
    .g_max        (g_max),
    .b_min        (b_min),
    .b_max        (b_max),
    .cx           (cx),
    .cy           (cy),
    .match_count  (match_count),
    .target_found (target_found),
    .result_valid (result_valid),
    .busy         (busy)
  );

  // 100 MHz-style pixel clock
  always #5 dclk = ~dclk;

  // Cycle counter used for result latency
  always @(posedge dclk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input string name, input int ecx, input int ecy,
                                 input int ecnt, input int etf, input bit eskip);
    exp_t e;
    e.name = name; e.cx = ecx; e.cy = ecy; e.cnt = ecnt; e.tf = etf; e.skip = eskip;
    return e;
  endfunction

  function automatic logic [15:0] pixFor(input int mode, input int x, input int y,
                                         input int limit);
    case (mode)
      0:       return (x == 100 && y == 50) ? 16'hF800 : 16'h0000;
      1:       return (x >= 160 && x <= 167 && y >= 120 && y <= 127) ? 16'hF800 : 16'h0000;
      2:       return 16'hFFFF;
      3:       return 16'hC000;
      5:       return (y == 0 && x < limit) ? 16'hF800 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // Monitor: every result_valid must match the oldest expected result
  always @(negedge dclk) begin
    if (result_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        lat    = cycle - fallCycle;
        checkOutput({monExp.name, ".cx"}, 32'(cx), 32'(monExp.cx));
        checkOutput({monExp.name, ".cy"}, 32'(cy), 32'(monExp.cy));
        checkOutput({monExp.name, ".match_count"}, 32'(match_count), 32'(monExp.cnt));
        checkOutput({monExp.name, ".target_found"}, 32'(target_found), 32'(monExp.tf));
        if (monExp.skip)
          checkOutput({monExp.name, ".latency_short"}, 32'(lat >= 2 && lat <= 6), 32'd1);
        else
          checkOutput({monExp.name, ".latency_about30"}, 32'(lat >= 25 && lat <= 35), 32'd1);
      end
    end
  end

  task automatic setWindow(input int rlo, input int rhi, input int glo, input int ghi,
                           input int blo, input int bhi);
    r_min = 5'(rlo); r_max = 5'(rhi);
    g_min = 6'(glo); g_max = 6'(ghi);
    b_min = 5'(blo); b_max = 5'(bhi);
  endtask

  // One frame of npix back-to-back pixels in raster order; mode 3 moves
  // r_min to 31 at the start of line 10
  task automatic applyStimulus(input exp_t e, input int mode, input int npix,
                               input int limit, input bit expectResult);
    @(negedge dclk);
    frame_active = 1'b1;
    @(negedge dclk);
    for (int i = 0; i < npix; i++) begin
      pix_valid = 1'b1;
      pix_data  = pixFor(mode, i % 320, i / 320, limit);
      if (mode == 3 && (i / 320) == 10 && (i % 320) == 0) r_min = 5'd31;
      @(negedge dclk);
    end
    pix_valid    = 1'b0;
    pix_data     = 16'h0000;
    frame_active = 1'b0;
    fallCycle    = cycle;
    if (expectResult) begin
      sbQ.push_back(e);
      for (int i = 0; i < 60 && sbQ.size() != 0; i++) @(negedge dclk);
      if (sbQ.size() != 0) begin
        checkOutput({e.name, ".timeout_pending"}, 32'(sbQ.size()), 32'd0);
        sbQ.delete();
      end
      repeat (5) @(negedge dclk);
    end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; frame_active = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
    setWindow(20, 31, 0, 10, 0, 10);
    repeat (3) @(negedge dclk);
    rst = 1'b0;
    @(negedge dclk);
    checkOutput("reset.cx", 32'(cx), 32'd0);
    checkOutput("reset.cy", 32'(cy), 32'd0);
    checkOutput("reset.match_count", 32'(match_count), 32'd0);
    checkOutput("reset.target_found", 32'(target_found), 32'd0);
    checkOutput("reset.result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);

    $display("[TB] single red pixel at (100,50)");
    applyStimulus(mkExp("single", 100, 50, 1, 0, 1'b0), 0, 50*320 + 101, 0, 1'b1);

    $display("[TB] 8x8 red block at x=160..167, y=120..127");
    applyStimulus(mkExp("block", 163, 123, 64, 1, 1'b0), 1, 127*320 + 168, 0, 1'b1);

    $display("[TB] open window, 16 full white lines");
    setWindow(0, 31, 0, 63, 0, 31);
    applyStimulus(mkExp("open16", 159, 7, 5120, 1, 1'b0), 2, 16*320, 0, 1'b1);

    $display("[TB] empty frame");
    setWindow(20, 31, 0, 10, 0, 10);
    applyStimulus(mkExp("empty", 0, 0, 0, 0, 1'b1), 4, 320, 0, 1'b1);

    $display("[TB] inverted green window");
    setWindow(0, 31, 10, 5, 0, 31);
    applyStimulus(mkExp("inverted", 0, 0, 0, 0, 1'b1), 2, 320, 0, 1'b1);

    $display("[TB] 63 and 64 pixel threshold boundary");
    setWindow(20, 31, 0, 10, 0, 10);
    applyStimulus(mkExp("count63", 31, 0, 63, 0, 1'b0), 5, 320, 63, 1'b1);
    applyStimulus(mkExp("count64", 31, 0, 64, 1, 1'b0), 5, 320, 64, 1'b1);

    $display("[TB] r_min change during line 10");
    applyStimulus(mkExp("midchange", 159, 5, 3840, 1, 1'b0), 3, 12*320, 0, 1'b1);
    applyStimulus(mkExp("nextframe", 0, 0, 0, 0, 1'b1), 3, 12*320, 0, 1'b1);

    $display("[TB] reset during divide");
    setWindow(0, 31, 0, 63, 0, 31);
    applyStimulus(mkExp("aborted", 0, 0, 0, 0, 1'b0), 2, 320, 0, 1'b0);
    repeat (10) @(negedge dclk);
    checkOutput("rstdiv.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge dclk);
    rst = 1'b0;
    checkOutput("rstdiv.cx", 32'(cx), 32'd0);
    checkOutput("rstdiv.cy", 32'(cy), 32'd0);
    checkOutput("rstdiv.match_count", 32'(match_count), 32'd0);
    checkOutput("rstdiv.target_found", 32'(target_found), 32'd0);
    checkOutput("rstdiv.busy_after", 32'(busy), 32'd0);
    repeat (50) @(negedge dclk);

    $display("[TB] frame after reset");
    setWindow(20, 31, 0, 10, 0, 10);
    applyStimulus(mkExp("afterrst", 49, 0, 100, 1, 1'b0), 5, 320, 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
